vga_timing_core: RTL and testbench
==================================

VGA_TIMING_CORE -- requirements
Module: vga_timing_core

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible columns.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible rows.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameter HS_POL, default 0: asserted HSYNC level.
REQ-010 SHALL have parameter VS_POL, default 0: asserted VSYNC level.
REQ-011 SHALL have parameters RW/GW/BW, defaults 3/3/2: colour channel widths.
REQ-012 SHALL have parameter RD_LAT, default 1, range 0..4: framebuffer read latency, in pixel beats.
REQ-013 SHALL have parameter CW, default 10: ROW/COLUMN width.
REQ-014 SHALL have port CLK, input, 1 bit: the single clock.
REQ-015 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-016 SHALL have port PIX_EN, input, 1 bit: pixel-beat enable.
REQ-017 SHALL have ports RED, GREEN, BLUE, inputs, RW/GW/BW bits: framebuffer colour data.
REQ-018 SHALL have ports ROW and COLUMN, outputs, CW bits each: pixel address presented to the framebuffer.
REQ-019 SHALL have ports ROUT, GOUT, BOUT, outputs, RW/GW/BW bits: colour driven to the DAC pins.
REQ-020 SHALL have ports HSYNC and VSYNC, outputs, 1 bit each: sync signals.
REQ-021 SHALL have port ACTIVE, output, 1 bit: visible-pixel flag, aligned with ROUT/GOUT/BOUT.
REQ-022 SHALL have ports FRAME_START and LINE_START, outputs, 1 bit each: single-CLK pulses.

Function
REQ-023 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-024 SHALL update all state only on CLK edges where PIX_EN=1; a beat is one such edge.
REQ-025 SHALL count h from 0 to H_TOTAL-1, then wrap to 0.
REQ-026 SHALL increment v on each h wrap, and wrap v to 0 after V_TOTAL-1.
REQ-027 SHALL register h and v onto COLUMN and ROW at each beat, covering the full range including blanking.
REQ-028 SHALL treat a pixel (h,v) as active iff h<H_ACTIVE and v<V_ACTIVE.
REQ-029 SHALL treat sync as asserted when h lies in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for v with V parameters.
REQ-030 SHALL carry each pixel's active, hsync, vsync, col0 and frame0 flags through an enable-gated delay of RD_LAT beats.
REQ-031 SHALL sample RED/GREEN/BLUE RD_LAT beats after the matching ROW/COLUMN beat.
REQ-032 SHALL drive ROUT/GOUT/BOUT = sampled colour when the delayed active flag is 1, and 0 otherwise.
REQ-033 SHALL make HSYNC, VSYNC and ACTIVE change on the same beat as the colour of their pixel (latency RD_LAT+1 beats from counter).
REQ-034 SHALL drive HSYNC = HS_POL when sync is asserted and ~HS_POL otherwise; VSYNC SHALL follow the same rule with VS_POL.
REQ-035 SHALL drive FRAME_START high for exactly one CLK, on the beat pixel (0,0) reaches the output, even if PIX_EN stays high across cycles.
REQ-036 SHALL drive LINE_START high for exactly one CLK, on the beat column 0 of any row reaches the output.
REQ-037 SHALL hold all outputs, and drive both pulses low, on cycles where PIX_EN=0.
REQ-038 SHALL raise an elaboration error if 2^CW ≤ max(H_TOTAL-1, V_TOTAL-1) or RD_LAT>4.

Reset
REQ-039 SHALL, while RST=1, clear h, v, ROW, COLUMN, colours, ACTIVE, pulses and every delay stage to 0, asynchronously.
REQ-040 SHALL drive HSYNC=~HS_POL and VSYNC=~VS_POL while RST=1.
REQ-041 SHALL, on reset assertion mid-frame, abandon the frame and start the first post-release beat at (0,0).

Structure
REQ-042 SHALL take the 640x480@60 timing constants and an RGB width typedef from shared package vga_pkg.
REQ-043 SHALL implement the delay as sub-module vga_delay_line, with parameters WIDTH/DEPTH (DEPTH=0 means pass-through), an enable input, and async reset to a parametrised init value.

Verification
REQ-044 SHALL check defaults, PIX_EN=1, RD_LAT=1: line = 800 CLK, HSYNC low 96 consecutive cycles, VSYNC low 1600 cycles, frame = 420000 CLK.
REQ-045 SHALL check RED=7 held: ROUT=7 for 640 beats and 0 for 160 beats per line, and ROUT=0 throughout rows 480..524.
REQ-046 SHALL check RD_LAT=2 with a RAM model returning RED=COLUMN[2:0] two beats late: ROUT sequence is 0,1,..7 repeating, first value coincident with the ACTIVE rise.
REQ-047 SHALL check PIX_EN toggling 1,0,1,0: line = 1600 CLK, outputs stable on disabled cycles, FRAME_START one CLK wide.
REQ-048 SHALL check HS_POL=VS_POL=1 with H 8/1/2/1 and V 4/1/1/1: HSYNC high 2 of every 12 beats, VSYNC high 1 of 7 lines.
REQ-049 SHALL check RST pulse at row 2: outputs reach reset values immediately, and FRAME_START fires RD_LAT+1 beats after release.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg -- 640x480@60 timing constants and shared VGA types.   Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef logic [2:0] vga_red_t;
    typedef logic [2:0] vga_green_t;
    typedef logic [1:0] vga_blue_t;

    typedef struct packed {
        vga_red_t   r;
        vga_green_t g;
        vga_blue_t  b;
    } vga_rgb_t;

    // Per-pixel timing flags that travel alongside the framebuffer read.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic col0;
        logic frame0;
    } vga_flags_t;

    localparam int VGA_FLAGS_W = $bits(vga_flags_t);

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_delay_line -- enable-gated shift register; DEPTH=0 is a pass-through.
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk_i, rst_i, en_i};
        assign q_o       = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= INIT;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_core -- VGA raster counters, sync generation and colour gating
// aligned to a framebuffer with RD_LAT beats of read latency.   Rev 1.0
// ----------------------------------------------------------------------------
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RW       = $bits(vga_red_t),
    parameter int GW       = $bits(vga_green_t),
    parameter int BW       = $bits(vga_blue_t),
    parameter int RD_LAT   = 1,
    parameter int CW       = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PIX_EN,
    input  logic [RW-1:0] RED,
    input  logic [GW-1:0] GREEN,
    input  logic [BW-1:0] BLUE,
    output logic [CW-1:0] ROW,
    output logic [CW-1:0] COLUMN,
    output logic [RW-1:0] ROUT,
    output logic [GW-1:0] GOUT,
    output logic [BW-1:0] BOUT,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          ACTIVE,
    output logic          FRAME_START,
    output logic          LINE_START
);

    localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint MAX_CNT = longint'((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) - 1;

    if (((longint'(1) << CW) <= MAX_CNT) || (RD_LAT > 4) || (RD_LAT < 0)) begin : g_param_check
        $error("vga_timing_core: CW too narrow for the raster or RD_LAT outside 0..4");
    end

    // One extra bit so range ends equal to 2^CW still compare correctly.
    localparam logic [CW:0]   H_ACT_END  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   V_ACT_END  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW:0]   h_ext, v_ext;
    vga_flags_t    flags_cur;
    vga_flags_t    flags_dly;

    logic [RW-1:0] rout_q, rout_d;
    logic [GW-1:0] gout_q, gout_d;
    logic [BW-1:0] bout_q, bout_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          frame_start_q, frame_start_d;
    logic          line_start_q, line_start_d;

    always_comb begin
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end
    end

    assign h_ext = {1'b0, h_q};
    assign v_ext = {1'b0, v_q};

    always_comb begin
        flags_cur        = '0;
        flags_cur.active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        flags_cur.hsync  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
        flags_cur.vsync  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
        flags_cur.col0   = (h_q == '0);
        flags_cur.frame0 = (h_q == '0) && (v_q == '0);
    end

    // Flags wait RD_LAT beats so they meet the colour of the same pixel.
    vga_delay_line #(
        .WIDTH (VGA_FLAGS_W),
        .DEPTH (RD_LAT),
        .INIT  ({VGA_FLAGS_W{1'b0}})
    ) u_flag_dly (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (PIX_EN),
        .d_i   (flags_cur),
        .q_o   (flags_dly)
    );

    always_comb begin
        rout_d        = '0;
        gout_d        = '0;
        bout_d        = '0;
        active_d      = flags_dly.active;
        hsync_d       = flags_dly.hsync ? HS_POL : ~HS_POL;
        vsync_d       = flags_dly.vsync ? VS_POL : ~VS_POL;
        frame_start_d = PIX_EN & flags_dly.frame0;
        line_start_d  = PIX_EN & flags_dly.col0;
        if (flags_dly.active) begin
            rout_d = RED;
            gout_d = GREEN;
            bout_d = BLUE;
        end
    end

    // Pulses re-evaluate every clock so they drop on the first disabled cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q           <= '0;
            v_q           <= '0;
            rout_q        <= '0;
            gout_q        <= '0;
            bout_q        <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            if (PIX_EN) begin
                h_q      <= h_d;
                v_q      <= v_d;
                rout_q   <= rout_d;
                gout_q   <= gout_d;
                bout_q   <= bout_d;
                active_q <= active_d;
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
            end
        end
    end

    assign COLUMN      = h_q;
    assign ROW         = v_q;
    assign ROUT        = rout_q;
    assign GOUT        = gout_q;
    assign BOUT        = bout_q;
    assign ACTIVE      = active_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign FRAME_START = frame_start_q;
    assign LINE_START  = line_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_timing_core -- directed checks of raster timing, latency alignment,
// enable gating, polarity and reset on four parameterisations.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_vga_timing_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 640x480 default timing, pixel p at the output (p<0: still in the pipeline)
    function automatic void model_std(input int p, output int e_act, output int e_hs,
                                      output int e_fs, output int e_ls);
        int c, r;
        if (p < 0) begin
            e_act = 0; e_hs = 1; e_fs = 0; e_ls = 0;
        end else begin
            c     = p % 800;
            r     = p / 800;
            e_act = (c < 640 && r < 480) ? 1 : 0;
            e_hs  = (c >= 656 && c < 752) ? 0 : 1;
            e_fs  = (p % 420000 == 0) ? 1 : 0;
            e_ls  = (c == 0) ? 1 : 0;
        end
    endfunction

    // DUT A: defaults, constant colour
    logic rst_a = 1'b1, en_a = 1'b1;
    logic [2:0] red_a = 3'd7, grn_a = 3'd5;
    logic [1:0] blu_a = 2'd2;
    logic [9:0] row_a, col_a;
    logic [2:0] rout_a, gout_a;
    logic [1:0] bout_a;
    logic hs_a, vs_a, act_a, fs_a, ls_a;

    vga_timing_core u_dut_a (
        .CLK(clk), .RST(rst_a), .PIX_EN(en_a), .RED(red_a), .GREEN(grn_a), .BLUE(blu_a),
        .ROW(row_a), .COLUMN(col_a), .ROUT(rout_a), .GOUT(gout_a), .BOUT(bout_a),
        .HSYNC(hs_a), .VSYNC(vs_a), .ACTIVE(act_a), .FRAME_START(fs_a), .LINE_START(ls_a)
    );

    // DUT B: RD_LAT=2 behind a two-stage RAM model
    logic rst_b = 1'b1, en_b = 1'b1;
    logic [2:0] ram1_b = 3'd0, ram2_b = 3'd0, grn_b = 3'd3;
    logic [1:0] blu_b = 2'd1;
    logic [9:0] row_b, col_b;
    logic [2:0] rout_b, gout_b;
    logic [1:0] bout_b;
    logic hs_b, vs_b, act_b, fs_b, ls_b;

    always @(posedge clk) begin
        if (en_b) begin
            ram1_b <= col_b[2:0];
            ram2_b <= ram1_b;
        end
    end

    vga_timing_core #(.RD_LAT(2)) u_dut_b (
        .CLK(clk), .RST(rst_b), .PIX_EN(en_b), .RED(ram2_b), .GREEN(grn_b), .BLUE(blu_b),
        .ROW(row_b), .COLUMN(col_b), .ROUT(rout_b), .GOUT(gout_b), .BOUT(bout_b),
        .HSYNC(hs_b), .VSYNC(vs_b), .ACTIVE(act_b), .FRAME_START(fs_b), .LINE_START(ls_b)
    );

    // DUT C: tiny raster, positive syncs, RD_LAT=0
    logic rst_c = 1'b1, en_c = 1'b1;
    logic [2:0] red_c = 3'd5, grn_c = 3'd6;
    logic [1:0] blu_c = 2'd3;
    logic [3:0] row_c, col_c;
    logic [2:0] rout_c, gout_c;
    logic [1:0] bout_c;
    logic hs_c, vs_c, act_c, fs_c, ls_c;

    vga_timing_core #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(0), .CW(4)
    ) u_dut_c (
        .CLK(clk), .RST(rst_c), .PIX_EN(en_c), .RED(red_c), .GREEN(grn_c), .BLUE(blu_c),
        .ROW(row_c), .COLUMN(col_c), .ROUT(rout_c), .GOUT(gout_c), .BOUT(bout_c),
        .HSYNC(hs_c), .VSYNC(vs_c), .ACTIVE(act_c), .FRAME_START(fs_c), .LINE_START(ls_c)
    );

    // DUT D: short lines, default vertical timing
    logic rst_d = 1'b1, en_d = 1'b1;
    logic [2:0] red_d = 3'd7, grn_d = 3'd1;
    logic [1:0] blu_d = 2'd1;
    logic [9:0] row_d, col_d;
    logic [2:0] rout_d, gout_d;
    logic [1:0] bout_d;
    logic hs_d, vs_d, act_d, fs_d, ls_d;

    vga_timing_core #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)) u_dut_d (
        .CLK(clk), .RST(rst_d), .PIX_EN(en_d), .RED(red_d), .GREEN(grn_d), .BLUE(blu_d),
        .ROW(row_d), .COLUMN(col_d), .ROUT(rout_d), .GOUT(gout_d), .BOUT(bout_d),
        .HSYNC(hs_d), .VSYNC(vs_d), .ACTIVE(act_d), .FRAME_START(fs_d), .LINE_START(ls_d)
    );

    initial begin
        int p, c, r, e_act, e_hs, e_vs, e_fs, e_ls;
        int hs_run, cnt7, cnt0, last_ls, last_fs, fs_cnt, rise_n, guard, hs_hi, vs_hi, vs_lo, blank_hot;

        repeat (3) step();
        check_eq("rst_a_row", row_a, 0);
        check_eq("rst_a_col", col_a, 0);
        check_eq("rst_a_rout", rout_a, 0);
        check_eq("rst_a_act", act_a, 0);
        check_eq("rst_a_hs", hs_a, 1);
        check_eq("rst_a_vs", vs_a, 1);
        check_eq("rst_a_fs", fs_a, 0);
        check_eq("rst_a_ls", ls_a, 0);
        check_eq("rst_c_hs", hs_c, 0);
        check_eq("rst_c_vs", vs_c, 0);

        // A: two full lines against the default timing
        rst_a = 1'b0;
        hs_run = 0; cnt7 = 0; cnt0 = 0; last_ls = -1;
        for (int n = 1; n <= 1700; n++) begin
            step();
            p = n - 2;
            model_std(p, e_act, e_hs, e_fs, e_ls);
            check_eq("a_col", col_a, n % 800);
            check_eq("a_row", row_a, n / 800);
            check_eq("a_act", act_a, e_act);
            check_eq("a_rout", rout_a, e_act ? 7 : 0);
            check_eq("a_gout", gout_a, e_act ? 5 : 0);
            check_eq("a_bout", bout_a, e_act ? 2 : 0);
            check_eq("a_hs", hs_a, e_hs);
            check_eq("a_vs", vs_a, 1);
            check_eq("a_fs", fs_a, e_fs);
            check_eq("a_ls", ls_a, e_ls);
            if (!hs_a) begin
                hs_run++;
            end else begin
                if (hs_run > 0) check_eq("a_hs_low_clk", hs_run, 96);
                hs_run = 0;
            end
            if (p >= 0 && p < 800) begin
                if (rout_a == 3'd7) cnt7++;
                else if (rout_a == 3'd0) cnt0++;
            end
            if (ls_a) begin
                if (last_ls >= 0) check_eq("a_line_clk", n - last_ls, 800);
                last_ls = n;
            end
        end
        check_eq("a_rout7_beats", cnt7, 640);
        check_eq("a_rout0_beats", cnt0, 160);

        // A: PIX_EN toggling 1,0,1,0
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        fs_cnt = 0; last_ls = -1;
        for (int k = 1; k <= 1700; k++) begin
            en_a = (k % 2 == 1);
            step();
            p = (k + 1) / 2 - 2;
            model_std(p, e_act, e_hs, e_fs, e_ls);
            check_eq("t_col", col_a, ((k + 1) / 2) % 800);
            check_eq("t_act", act_a, e_act);
            check_eq("t_rout", rout_a, e_act ? 7 : 0);
            check_eq("t_hs", hs_a, e_hs);
            check_eq("t_fs", fs_a, en_a ? e_fs : 0);
            check_eq("t_ls", ls_a, en_a ? e_ls : 0);
            if (fs_a) fs_cnt++;
            if (ls_a) begin
                if (last_ls >= 0) check_eq("t_line_clk", k - last_ls, 1600);
                last_ls = k;
            end
        end
        check_eq("t_fs_clk_wide", fs_cnt, 1);

        // A: reset pulse in row 2
        en_a  = 1'b1;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        guard = 0;
        while (row_a != 10'd2 && guard < 2000) begin
            step();
            guard++;
        end
        check_eq("r_reach_row2", row_a, 2);
        repeat (100) step();
        rst_a = 1'b1;
        #1;
        check_eq("r_row", row_a, 0);
        check_eq("r_col", col_a, 0);
        check_eq("r_act", act_a, 0);
        check_eq("r_rout", rout_a, 0);
        check_eq("r_gout", gout_a, 0);
        check_eq("r_bout", bout_a, 0);
        check_eq("r_hs", hs_a, 1);
        check_eq("r_vs", vs_a, 1);
        check_eq("r_fs", fs_a, 0);
        check_eq("r_ls", ls_a, 0);
        step();
        rst_a = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            check_eq("r_post_col", col_a, n);
            check_eq("r_post_row", row_a, 0);
            check_eq("r_post_fs", fs_a, (n == 2) ? 1 : 0);
        end

        // B: RD_LAT=2, RAM returns COLUMN[2:0]
        rst_b = 1'b0;
        rise_n = -1;
        for (int n = 1; n <= 1700; n++) begin
            step();
            p = n - 3;
            e_act = (p >= 0 && (p % 800) < 640) ? 1 : 0;
            check_eq("b_act", act_b, e_act);
            check_eq("b_rout", rout_b, e_act ? (p % 800) % 8 : 0);
            check_eq("b_gout", gout_b, e_act ? 3 : 0);
            check_eq("b_fs", fs_b, (p == 0) ? 1 : 0);
            if (act_b && rise_n < 0) begin
                rise_n = n;
                check_eq("b_rise_rout", rout_b, 0);
            end
        end
        check_eq("b_rise_beat", rise_n, 3);

        // C: 12x7 raster, positive syncs, RD_LAT=0
        rst_c = 1'b0;
        hs_hi = 0; vs_hi = 0; last_fs = -1;
        for (int n = 1; n <= 200; n++) begin
            step();
            p = n - 1;
            c = p % 12;
            r = (p / 12) % 7;
            e_act = (c < 8 && r < 4) ? 1 : 0;
            check_eq("c_col", col_c, n % 12);
            check_eq("c_row", row_c, (n / 12) % 7);
            check_eq("c_act", act_c, e_act);
            check_eq("c_rout", rout_c, e_act ? 5 : 0);
            check_eq("c_bout", bout_c, e_act ? 3 : 0);
            check_eq("c_hs", hs_c, (c == 9 || c == 10) ? 1 : 0);
            check_eq("c_vs", vs_c, (r == 5) ? 1 : 0);
            check_eq("c_fs", fs_c, (p % 84 == 0) ? 1 : 0);
            check_eq("c_ls", ls_c, (c == 0) ? 1 : 0);
            if (p < 84) begin
                if (hs_c) hs_hi++;
                if (vs_c) vs_hi++;
            end
            if (fs_c) begin
                if (last_fs >= 0) check_eq("c_frame_clk", n - last_fs, 84);
                last_fs = n;
            end
        end
        check_eq("c_hs_high_beats", hs_hi, 14);
        check_eq("c_vs_high_beats", vs_hi, 12);

        // D: full 525-line frame with short lines
        rst_d = 1'b0;
        vs_lo = 0; blank_hot = 0; last_fs = -1;
        for (int n = 1; n <= 6400; n++) begin
            step();
            p = n - 2;
            if (p < 0) begin
                e_act = 0; e_hs = 1; e_vs = 1; e_fs = 0; r = 0;
            end else begin
                c     = p % 12;
                r     = (p / 12) % 525;
                e_act = (c < 8 && r < 480) ? 1 : 0;
                e_hs  = (c == 9 || c == 10) ? 0 : 1;
                e_vs  = (r == 490 || r == 491) ? 0 : 1;
                e_fs  = (p % 6300 == 0) ? 1 : 0;
            end
            check_eq("d_col", col_d, n % 12);
            check_eq("d_row", row_d, (n / 12) % 525);
            check_eq("d_act", act_d, e_act);
            check_eq("d_rout", rout_d, e_act ? 7 : 0);
            check_eq("d_hs", hs_d, e_hs);
            check_eq("d_vs", vs_d, e_vs);
            check_eq("d_fs", fs_d, e_fs);
            if (p >= 0 && p < 6300) begin
                if (!vs_d) vs_lo++;
                if (r >= 480 && rout_d != 3'd0) blank_hot++;
            end
            if (fs_d) begin
                if (last_fs >= 0) check_eq("d_frame_clk", n - last_fs, 6300);
                last_fs = n;
            end
        end
        check_eq("d_vs_low_clk", vs_lo, 24);
        check_eq("d_blank_rows_rout", blank_hot, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
